// File: rtl/csa_blk_enc_core.sv
// ---------------------------------------------------------------------------
// csa_blk_enc_core
//   Block-cipher stage of the TS scrambler. Buffers one 188-byte MPEG-TS
//   packet, encrypts the 184-byte payload as 23 big-endian 64-bit blocks
//   with reverse chaining (C_i = E(P_i ^ C_{i+1}), C_24 = 0, i = 23..1),
//   then streams the packet out byte-serially.
//
//   E(X) = ROUNDS x { X = rotl64(S(X ^ K), 8) }, one round per clock.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   en_count_packet/count_packet, en_pid_num/pid_num,
//   en_gbe_num/gbe_num, en_ip_port/ip_port
//                              sideband values, latched on their strobes
//   en_tsf, tsf                TS input byte stream (contiguous per packet)
//   en_cwr, cwr                control-word frame: ctrl byte + 8 key bytes
//   finish_blk_enc             one-cycle pulse after the last output byte
//   en_tsr, tsr                TS output byte stream (188 contiguous bytes)
//
// Handshake: streams are valid-only. A byte is taken on every rising edge
// where its valid is high; there is no back-pressure in either direction.
//
// Build option: define TSC_MARK_EN to overwrite byte3[7:6] of encrypted
// packets with 2'b10 (even key) or 2'b11 (odd key).
// ---------------------------------------------------------------------------
module csa_blk_enc_core #(
  parameter int ROUNDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_count_packet,
  input  logic [7:0] count_packet,
  input  logic [7:0] pid_num,
  input  logic       en_pid_num,
  input  logic [7:0] gbe_num,
  input  logic       en_gbe_num,
  input  logic [7:0] ip_port,
  input  logic       en_ip_port,
  input  logic       en_tsf,
  input  logic [7:0] tsf,
  input  logic       en_cwr,
  input  logic [7:0] cwr,
  output logic       finish_blk_enc,
  output logic       en_tsr,
  output logic [7:0] tsr
);

  typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, ENC = 2'd2, TX = 2'd3} state_t;

  localparam logic [7:0] LAST_IDX = 8'd187;
  localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  4'hF: r = 4'h2;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] round_fn(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] s;
    for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox4(x[4*i +: 4] ^ k[4*i +: 4]);
    return {s[55:0], s[63:56]};
  endfunction

  // State is visible to bound checkers through this signal.
  state_t state, state_next;

  logic [7:0]  buf_mem [0:187];
  logic [7:0]  idx;            // RX write index, reused as TX read index
  logic [4:0]  blk;            // current payload block, 23 down to 1
  logic [7:0]  rnd;
  logic [63:0] x_reg, chain, blk_data, round_in, round_out;
  logic [7:0]  base;
  logic        last_round, enc_go, fin_next;

  logic [63:0] key_even, key_odd;
  logic        key_valid, act_par;
  logic [3:0]  cw_cnt;
  logic        cw_par;
  logic [55:0] cw_shift;

  logic [63:0] pkt_key;
  logic        pkt_par, pkt_kv, pkt_enc;

  logic [7:0]  sb_count, sb_pid, sb_gbe, sb_ip;
  logic [7:0]  snap_count, snap_pid, snap_gbe, snap_ip;
  logic        unused_sideband;

  // Sideband snapshot is carried for future header use; it has no data effect.
  assign unused_sideband = ^{snap_count, snap_pid, snap_gbe, snap_ip, pkt_par, pkt_enc};

  // ---------------- CW frame loader ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_cnt    <= '0;
      cw_par    <= 1'b0;
      cw_shift  <= '0;
      key_even  <= '0;
      key_odd   <= '0;
      key_valid <= 1'b0;
      act_par   <= 1'b0;
    end else if (en_cwr) begin
      if (cw_cnt != 4'd9) cw_cnt <= cw_cnt + 4'd1;
      if (cw_cnt == 4'd0) begin
        cw_par <= cwr[0];
      end else if (cw_cnt < 4'd8) begin
        cw_shift <= {cw_shift[47:0], cwr};
      end else if (cw_cnt == 4'd8) begin
        if (cw_par) key_odd  <= {cw_shift, cwr};
        else        key_even <= {cw_shift, cwr};
        act_par   <= cw_par;
        key_valid <= 1'b1;
      end
    end else begin
      cw_cnt <= '0;   // a frame shorter than 9 bytes never reaches the bank write
    end
  end

  // ---------------- Sideband latches ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_count <= '0; sb_pid <= '0; sb_gbe <= '0; sb_ip <= '0;
    end else begin
      if (en_count_packet) sb_count <= count_packet;
      if (en_pid_num)      sb_pid   <= pid_num;
      if (en_gbe_num)      sb_gbe   <= gbe_num;
      if (en_ip_port)      sb_ip    <= ip_port;
    end
  end

  // ---------------- Cipher datapath ----------------
  assign base       = 8'd4 + {blk - 5'd1, 3'b000};
  assign last_round = (state == ENC) && (rnd == LAST_RND);
  assign enc_go     = (buf_mem[0] == 8'h47) && pkt_kv;

  always_comb begin
    blk_data = '0;
    for (int j = 0; j < 8; j++) blk_data[63-8*j -: 8] = buf_mem[base + 8'(j)];
  end

  // First round of a block takes the chained plaintext straight from the buffer.
  assign round_in  = (rnd == 8'd0) ? (blk_data ^ chain) : x_reg;
  assign round_out = round_fn(round_in, pkt_key);

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state;
    fin_next   = 1'b0;
    unique case (state)
      IDLE: if (en_tsf) state_next = RX;
      RX: begin
        if (!en_tsf)               state_next = IDLE;
        else if (idx == LAST_IDX)  state_next = enc_go ? ENC : TX;
      end
      ENC: if (last_round && blk == 5'd1) state_next = TX;
      TX: begin
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          fin_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      finish_blk_enc <= 1'b0;
      idx            <= '0;
      blk            <= '0;
      rnd            <= '0;
      x_reg          <= '0;
      chain          <= '0;
      pkt_key        <= '0;
      pkt_par        <= 1'b0;
      pkt_kv         <= 1'b0;
      pkt_enc        <= 1'b0;
      snap_count     <= '0; snap_pid <= '0; snap_gbe <= '0; snap_ip <= '0;
    end else begin
      state          <= state_next;
      finish_blk_enc <= fin_next;
      unique case (state)
        IDLE: if (en_tsf) begin
          idx        <= 8'd1;
          pkt_key    <= act_par ? key_odd : key_even;
          pkt_par    <= act_par;
          pkt_kv     <= key_valid;
          pkt_enc    <= 1'b0;
          snap_count <= sb_count; snap_pid <= sb_pid;
          snap_gbe   <= sb_gbe;   snap_ip  <= sb_ip;
        end
        RX: if (en_tsf) begin
          if (idx == LAST_IDX) begin
            idx     <= '0;
            blk     <= 5'd23;
            rnd     <= '0;
            chain   <= '0;
            pkt_enc <= enc_go;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        ENC: begin
          x_reg <= round_out;
          if (last_round) begin
            rnd   <= '0;
            blk   <= blk - 5'd1;
            chain <= round_out;
          end else begin
            rnd <= rnd + 8'd1;
          end
        end
        TX: idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
        default: ;
      endcase
    end
  end

  // Packet buffer: contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (state == IDLE && en_tsf) begin
      buf_mem[0] <= tsf;
    end else if (state == RX && en_tsf) begin
      buf_mem[idx] <= tsf;
    end else if (last_round) begin
      for (int j = 0; j < 8; j++) buf_mem[base + 8'(j)] <= round_out[63-8*j -: 8];
    end
  end

  // ---------------- Output ----------------
  logic [7:0] tx_byte;
  always_comb begin
    tx_byte = buf_mem[idx];
`ifdef TSC_MARK_EN
    if (pkt_enc && idx == 8'd3) tx_byte = {1'b1, pkt_par, buf_mem[3][5:0]};
`endif
  end

  assign en_tsr = (state == TX);
  assign tsr    = en_tsr ? tx_byte : 8'h00;

endmodule

// File: tb/tb_csa_blk_enc_core.sv
// ---------------------------------------------------------------------------
// tb_csa_blk_enc_core
//   Directed bench for csa_blk_enc_core: reset values, pass-through, the
//   all-zero-key probe table, keyed packets against a byte-level reference
//   model, short CW frames, aborted packets, CW change during TX, and an
//   asynchronous reset during TX.
// ---------------------------------------------------------------------------
module tb_csa_blk_enc_core;

  localparam int ROUNDS = 8;
  localparam int ENC_CYC = 23 * ROUNDS;
  localparam logic [63:0] SBOX_NIB = 64'hC56B90AD3EF84712;
  localparam logic [63:0] KEY1 = 64'h123456789ABCDEF0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_count_packet = 0, en_pid_num = 0, en_gbe_num = 0, en_ip_port = 0;
  logic [7:0] count_packet = 0, pid_num = 0, gbe_num = 0, ip_port = 0;
  logic       en_tsf = 0, en_cwr = 0;
  logic [7:0] tsf = 0, cwr = 0;
  logic       finish_blk_enc, en_tsr;
  logic [7:0] tsr;

  csa_blk_enc_core #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst),
    .en_count_packet(en_count_packet), .count_packet(count_packet),
    .pid_num(pid_num), .en_pid_num(en_pid_num),
    .gbe_num(gbe_num), .en_gbe_num(en_gbe_num),
    .ip_port(ip_port), .en_ip_port(en_ip_port),
    .en_tsf(en_tsf), .tsf(tsf),
    .en_cwr(en_cwr), .cwr(cwr),
    .finish_blk_enc(finish_blk_enc), .en_tsr(en_tsr), .tsr(tsr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] pkt_buf [0:187];
  logic [7:0] cw_buf  [0:8];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int  first_tx_cyc, last_tx_cyc, fin_cyc, fin_cnt, last_in_cyc;
  bit  tx_seen;

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (en_tsr) begin
      if (!tx_seen) begin
        tx_seen      = 1'b1;
        first_tx_cyc = cyc;
      end
      last_tx_cyc = cyc;
      out_q.push_back(tsr);
    end
    if (finish_blk_enc) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    out_q.delete();
    tx_seen = 1'b0;
    fin_cnt = 0;
    first_tx_cyc = 0;
    last_tx_cyc = 0;
    fin_cyc = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cw(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_cwr = 1'b1;
      cwr    = cw_buf[i];
    end
    @(negedge clk);
    en_cwr = 1'b0;
    cwr    = 8'h00;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_tsf      = 1'b1;
      tsf         = pkt_buf[i];
      last_in_cyc = cyc;
    end
    @(negedge clk);
    en_tsf = 1'b0;
    tsf    = 8'h00;
  endtask

  // kind 0: zero payload, kind 1: payload 01..B8
  task automatic fill_pkt(input logic [7:0] b0, input int kind);
    pkt_buf[0] = b0; pkt_buf[1] = 8'h40; pkt_buf[2] = 8'h01; pkt_buf[3] = 8'h00;
    for (int i = 4; i < 188; i++) pkt_buf[i] = (kind == 1) ? 8'(i - 3) : 8'h00;
  endtask

  task automatic set_cw(input logic [7:0] ctrl, input logic [63:0] key);
    cw_buf[0] = ctrl;
    for (int i = 0; i < 8; i++) cw_buf[i+1] = key[63-8*i -: 8];
  endtask

  // ---------------- reference model (byte-oriented) ----------------
  function automatic logic [7:0] sub8(input logic [7:0] b);
    logic [63:0] t;
    t = SBOX_NIB;
    return {t[63-4*b[7:4] -: 4], t[63-4*b[3:0] -: 4]};
  endfunction

  task automatic model(input bit do_enc, input logic [63:0] key, input bit odd);
    logic [7:0] m  [0:187];
    logic [7:0] ch [0:7];
    logic [7:0] x  [0:7];
    logic [7:0] t  [0:7];
    logic [7:0] kb [0:7];
    for (int i = 0; i < 188; i++) m[i] = pkt_buf[i];
    if (do_enc) begin
      for (int j = 0; j < 8; j++) begin
        kb[j] = key[63-8*j -: 8];
        ch[j] = 8'h00;
      end
      for (int b = 22; b >= 0; b--) begin
        for (int j = 0; j < 8; j++) x[j] = m[4+8*b+j] ^ ch[j];
        for (int r = 0; r < ROUNDS; r++) begin
          for (int j = 0; j < 8; j++) t[j] = sub8(x[j] ^ kb[j]);
          for (int j = 0; j < 8; j++) x[j] = t[(j+1) % 8];   // rotate left one byte
        end
        for (int j = 0; j < 8; j++) begin
          m[4+8*b+j] = x[j];
          ch[j]      = x[j];
        end
      end
`ifdef TSC_MARK_EN
      m[3] = {1'b1, odd, m[3][5:0]};
`endif
    end
    if (odd && !do_enc) m[0] = m[0];  // parity only matters for encrypted packets
    exp_q.delete();
    for (int i = 0; i < 188; i++) exp_q.push_back(m[i]);
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (fin_cnt == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (fin_cnt == 0) check({name, "_timeout"}, 64'd0, 64'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_tx(input string name, input int limit);
    int k;
    k = 0;
    while (!tx_seen && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!tx_seen) check({name, "_tx_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_pkt(input string name, input int delay);
    check({name, "_len"}, out_q.size(), 188);
    for (int i = 0; i < 188; i++)
      check($sformatf("%s_byte%0d", name, i),
            (i < out_q.size()) ? {56'd0, out_q[i]} : 64'hDEAD, {56'd0, exp_q[i]});
    check({name, "_first_tx"}, first_tx_cyc, last_in_cyc + delay);
    check({name, "_last_tx"}, last_tx_cyc, first_tx_cyc + 187);
    check({name, "_fin_cnt"}, fin_cnt, 1);
    check({name, "_fin_cyc"}, fin_cyc, last_tx_cyc + 1);
  endtask

  task automatic run_pkt(input string name, input int delay);
    clear_mon();
    send_pkt(188);
    wait_done(name, 800);
    check_pkt(name, delay);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } probe_t;
  probe_t probes[12];

  int n0;

  initial begin
    // hand-derived values for the all-zero key / all-zero payload packet
    probes[0]  = '{0,   8'h47};
    probes[1]  = '{1,   8'h40};
    probes[2]  = '{2,   8'h01};
`ifdef TSC_MARK_EN
    probes[3]  = '{3,   8'h80};
`else
    probes[3]  = '{3,   8'h00};
`endif
    probes[4]  = '{164, 8'h99};
    probes[5]  = '{168, 8'h99};
    probes[6]  = '{171, 8'h99};
    probes[7]  = '{172, 8'h44};
    probes[8]  = '{179, 8'h44};
    probes[9]  = '{180, 8'hCC};
    probes[10] = '{184, 8'hCC};
    probes[11] = '{187, 8'hCC};

    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_en_tsr", en_tsr, 0);
    check("rst_tsr", tsr, 0);
    check("rst_finish", finish_blk_enc, 0);
    rst = 1'b0;

    // sideband strobes: latched but must not change data
    @(negedge clk);
    en_count_packet = 1; count_packet = 8'h11; en_pid_num = 1; pid_num = 8'h22;
    en_gbe_num = 1; gbe_num = 8'h33; en_ip_port = 1; ip_port = 8'h44;
    @(negedge clk);
    en_count_packet = 0; en_pid_num = 0; en_gbe_num = 0; en_ip_port = 0;

    // no CW since reset: pass-through
    fill_pkt(8'h47, 1);
    model(1'b0, 64'd0, 1'b0);
    run_pkt("nokey", 1);

    // all-zero key, even bank
    set_cw(8'h00, 64'd0);
    send_cw(9);
    fill_pkt(8'h47, 0);
    model(1'b1, 64'd0, 1'b0);
    run_pkt("zkey", 1 + ENC_CYC);
    for (int p = 0; p < 12; p++)
      check($sformatf("probe_%0d", probes[p].idx),
            (probes[p].idx < out_q.size()) ? {56'd0, out_q[probes[p].idx]} : 64'hDEAD,
            {56'd0, probes[p].exp});

    // odd key 0x123456789ABCDEF0
    set_cw(8'h07, KEY1);
    send_cw(9);
    fill_pkt(8'h47, 1);
    model(1'b1, KEY1, 1'b1);
    run_pkt("key1", 1 + ENC_CYC);
`ifdef TSC_MARK_EN
    check("key1_mark", (out_q.size() > 3) ? out_q[3] : 8'hxx, 8'hC0);
`else
    check("key1_hdr3", (out_q.size() > 3) ? out_q[3] : 8'hxx, 8'h00);
`endif

    // 5-byte CW frame (even parity, would select the zero key) is discarded
    set_cw(8'h06, 64'hAABBCCDD00000000);
    send_cw(5);
    model(1'b1, KEY1, 1'b1);
    run_pkt("short_cw", 1 + ENC_CYC);

    // sync byte 0x46: pass-through
    fill_pkt(8'h46, 1);
    model(1'b0, KEY1, 1'b1);
    run_pkt("p46", 1);

    // packet aborted after 100 bytes, then a normal one
    fill_pkt(8'h47, 1);
    clear_mon();
    send_pkt(100);
    repeat (400) @(negedge clk);
    check("drop_no_out", out_q.size(), 0);
    check("drop_no_fin", fin_cnt, 0);
    model(1'b1, KEY1, 1'b1);
    run_pkt("after_drop", 1 + ENC_CYC);

    // new CW (zero key, even) arrives during TX: this packet keeps KEY1
    clear_mon();
    send_pkt(188);
    wait_tx("cw_in_tx", 400);
    set_cw(8'h00, 64'd0);
    send_cw(9);
    wait_done("cw_in_tx", 800);
    check_pkt("cw_in_tx", 1 + ENC_CYC);
    fill_pkt(8'h47, 0);
    model(1'b1, 64'd0, 1'b0);
    run_pkt("next_key", 1 + ENC_CYC);

    // asynchronous reset in the middle of TX
    fill_pkt(8'h47, 1);
    clear_mon();
    send_pkt(188);
    wait_tx("rst_tx", 400);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_tx_en_tsr", en_tsr, 0);
    check("rst_tx_tsr", tsr, 0);
    n0 = out_q.size();
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("rst_tx_no_fin", fin_cnt, 0);
    check("rst_tx_no_more", out_q.size(), n0);

    // keys were cleared by reset: pass-through again
    model(1'b0, 64'd0, 1'b0);
    run_pkt("post_rst", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csa_blk_enc_core.md
Name: csa_blk_enc_core

Overview:
- Block-cipher stage of the TS scrambler.
- Loads a control word (CW) over a byte stream and buffers one 188-byte MPEG-TS packet.
- Encrypts the 184-byte payload as 23 eight-byte blocks with reverse chaining, then streams the packet out byte-serially.
- Sits between the TS packet splitter (tsf input) and the GbE packet builder (tsr output).

Parameters:
ROUNDS, 8, cipher rounds per 64-bit block; one round per clock.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en_count_packet  in  1  strobe for count_packet
count_packet  in  8  packet counter sideband
pid_num  in  8  PID index sideband
en_pid_num  in  1  strobe for pid_num
gbe_num  in  8  GbE port sideband
en_gbe_num  in  1  strobe for gbe_num
ip_port  in  8  IP port sideband
en_ip_port  in  1  strobe for ip_port
en_tsf  in  1  TS input byte valid (contiguous per packet)
tsf  in  8  TS input byte
en_cwr  in  1  CW frame byte valid (contiguous per frame)
cwr  in  8  CW frame byte
finish_blk_enc  out  1  one-cycle pulse, packet output complete
en_tsr  out  1  TS output byte valid
tsr  out  8  TS output byte

Behaviour:
- Reset:
  - finish_blk_enc=0, en_tsr=0, tsr=0.
  - Both key banks cleared; key_valid=0; active parity=0; sideband registers 0; FSM to IDLE.
- Sideband:
  - Each 8-bit value is latched when its strobe is high.
  - Snapshot taken at packet start; no effect on data in this revision.
- CW frame: 9 contiguous bytes while en_cwr=1.
  - Byte0 is control; bit0 = parity (1 = odd bank, 0 = even bank); other bits ignored.
  - Bytes1..8 form the 64-bit key, MSB first.
  - On the 9th byte the key is written to the selected bank, active parity is set to bit0, and key_valid=1.
  - Frame shorter than 9 bytes: discarded. Bytes beyond 9: ignored.
  - CW loading is accepted in any state; the key is sampled at packet start, so a new key applies from the next packet.
- FSM: IDLE -> RX -> ENC -> TX -> IDLE.
  - IDLE: first en_tsf byte goes to RX. The active key and parity are latched.
  - RX: bytes are written to a 188-byte buffer at index 0..187.
    - en_tsf dropping before 188 bytes: packet discarded, back to IDLE, no output.
    - Bytes beyond 188 in the burst: ignored.
  - ENC: encryption runs only if byte0==8'h47 and key_valid=1; otherwise ENC is skipped, which is clear pass-through.
    - Payload blocks P1..P23 = bytes 4..187, big-endian 64-bit.
    - Processed i=23 down to 1: C_i = E(P_i XOR C_{i+1}), with C_24 = 0.
    - Ciphertext is written back in place. ROUNDS cycles per block: 184 cycles with the default.
  - E(X): ROUNDS iterations of X = rotl64(S(X XOR K), 8), where S applies per nibble the 4-bit table 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - TX: en_tsr=1 for exactly 188 consecutive cycles, bytes 0..187 in order. Header bytes 0..3 are unchanged except as set by the optional feature.
    - TX starts the cycle after the last round, or the cycle after the last RX byte when ENC is skipped.
  - finish_blk_enc: high for one cycle, the cycle after the last en_tsr byte; then IDLE.
- en_tsf while in ENC or TX: ignored; the packet is lost.
- rst mid-operation: immediate abort; outputs low, buffer contents don't care.

Optional Feature:
- Macro TSC_MARK_EN.
- Defined: when a packet is encrypted, byte3[7:6] is overwritten with 2'b10 (even key) or 2'b11 (odd key). Pass-through packets are unchanged.
- Undefined: the header is always output unchanged.

Test Plan:
- Key all-zero (cwr 00,00x8), packet 47 40 01 00 + 184 zero bytes:
  - Output bytes 180..187 = CC repeated 8×, bytes 172..179 = 44 repeated 8×, bytes 164..171 = 99 repeated 8×.
  - Header 47 40 01 00; with TSC_MARK_EN the header is 47 40 01 80.
- CW frame 07,12,34,56,78,9a,bc,de,f0 then packet 47 40 01 00, payload 01..B8:
  - Payload matches the reference model with K=0x123456789ABCDEF0.
  - With TSC_MARK_EN, byte3=C0.
  - finish_blk_enc pulses once, 1 cycle after the 188th en_tsr.
- Packet with byte0=0x46, or with no CW loaded since reset: output is identical to the input, and TX starts 1 cycle after the last input byte.
- en_tsf dropped after 100 bytes: no en_tsr and no finish; the next full packet is processed normally.
- 5-byte CW frame: ignored, and the previous key is still used. New CW loaded during TX: the current packet uses the old key, the next packet uses the new one.
- rst pulsed during TX: en_tsr deasserts asynchronously; no finish pulse.
